// File: rtl/jump_issue_ctrl.sv
// Jump FU dispatch/resolve controller: one JAL/JALR/branch in flight, redirect + link writeback.
// Optional resolved-jump statistics counters under JUMP_STATS_EN.
module jump_issue_ctrl #(
  parameter int FU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        issue_jal,
  input  logic        issue_jalr,
  input  logic        issue_branch,
  input  logic [2:0]  issue_cmp_ctrl,
  input  logic [31:0] issue_rs1_data,
  input  logic [31:0] issue_rs2_data,
  input  logic [31:0] issue_imm,
  input  logic [31:0] issue_pc,
  input  logic [4:0]  issue_rd,
  input  logic        kill,
  output logic        fu_en,
  output logic        fu_jalr,
  output logic [2:0]  fu_cmp_ctrl,
  output logic [31:0] fu_rs1_data,
  output logic [31:0] fu_rs2_data,
  output logic [31:0] fu_imm,
  output logic [31:0] fu_pc,
  input  logic [31:0] fu_pc_jump,
  input  logic [31:0] fu_pc_wb,
  input  logic        fu_cmp_res,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        exc_misalign,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
`ifdef JUMP_STATS_EN
  output logic [31:0] stat_taken,
  output logic [31:0] stat_not_taken,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESOLVE, WB} state_t;

  localparam logic [2:0] LAST = 3'(FU_LAT - 1);

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic        jal_reg;
  logic        branch_reg;
  logic [4:0]  rd_reg;
  logic [31:0] pc_jump_reg;
  logic [31:0] pc_wb_reg;
  logic        cmp_res_reg;

  logic        taken;
  logic [31:0] target;
  logic        misalign;

  // fu_jalr doubles as the latched JALR op-class flag
  assign taken    = jal_reg | fu_jalr | (branch_reg & cmp_res_reg);
  assign target   = {pc_jump_reg[31:1], pc_jump_reg[0] & ~fu_jalr};
  assign misalign = taken & target[1];

  assign issue_ready = (state_reg == IDLE) & ~rst;
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      jal_reg        <= 1'b0;
      branch_reg     <= 1'b0;
      rd_reg         <= '0;
      pc_jump_reg    <= '0;
      pc_wb_reg      <= '0;
      cmp_res_reg    <= 1'b0;
      fu_en          <= 1'b0;
      fu_jalr        <= 1'b0;
      fu_cmp_ctrl    <= '0;
      fu_rs1_data    <= '0;
      fu_rs2_data    <= '0;
      fu_imm         <= '0;
      fu_pc          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      exc_misalign   <= 1'b0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
`ifdef JUMP_STATS_EN
      stat_taken     <= '0;
      stat_not_taken <= '0;
`endif
    end else begin
      fu_en          <= 1'b0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      exc_misalign   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue_valid) begin
            jal_reg     <= issue_jal;
            branch_reg  <= issue_branch;
            rd_reg      <= issue_rd;
            fu_jalr     <= issue_jalr;
            fu_cmp_ctrl <= issue_cmp_ctrl;
            fu_rs1_data <= issue_rs1_data;
            fu_rs2_data <= issue_rs2_data;
            fu_imm      <= issue_imm;
            fu_pc       <= issue_pc;
            cnt_reg     <= '0;
            fu_en       <= 1'b1;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          if (kill) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == LAST) begin
              pc_jump_reg <= fu_pc_jump;
              pc_wb_reg   <= fu_pc_wb;
              cmp_res_reg <= fu_cmp_res;
              state_reg   <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          // Pulses are registered here, so a kill seen this cycle cancels them outright
          if (kill) begin
            state_reg <= IDLE;
          end else begin
            if (misalign) begin
              exc_misalign <= 1'b1;
            end else if (taken) begin
              redirect_valid <= 1'b1;
              flush          <= 1'b1;
              redirect_pc    <= target;
            end
`ifdef JUMP_STATS_EN
            if (taken && !misalign) stat_taken <= stat_taken + 32'd1;
            if (!taken)             stat_not_taken <= stat_not_taken + 32'd1;
`endif
            if ((jal_reg | fu_jalr) && (rd_reg != 5'd0) && !misalign) begin
              wb_valid  <= 1'b1;
              wb_rd     <= rd_reg;
              wb_data   <= pc_wb_reg;
              state_reg <= WB;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_issue_ctrl.sv
// Scoreboard bench for jump_issue_ctrl: randomized ops, a per-op outcome model and a separate monitor.
module tb_jump_issue_ctrl;
  parameter int FU_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_jal, issue_jalr, issue_branch;
  logic [2:0]  issue_cmp_ctrl;
  logic [31:0] issue_rs1_data, issue_rs2_data, issue_imm, issue_pc;
  logic [4:0]  issue_rd;
  logic        kill;
  logic        fu_en, fu_jalr;
  logic [2:0]  fu_cmp_ctrl;
  logic [31:0] fu_rs1_data, fu_rs2_data, fu_imm, fu_pc;
  logic [31:0] fu_pc_jump, fu_pc_wb;
  logic        fu_cmp_res;
  logic        redirect_valid, flush, exc_misalign;
  logic [31:0] redirect_pc;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
`ifdef JUMP_STATS_EN
  logic [31:0] stat_taken, stat_not_taken;
`endif

  jump_issue_ctrl #(.FU_LAT(FU_LAT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_jal(issue_jal), .issue_jalr(issue_jalr), .issue_branch(issue_branch),
    .issue_cmp_ctrl(issue_cmp_ctrl),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rd(issue_rd),
    .kill(kill),
    .fu_en(fu_en), .fu_jalr(fu_jalr), .fu_cmp_ctrl(fu_cmp_ctrl),
    .fu_rs1_data(fu_rs1_data), .fu_rs2_data(fu_rs2_data), .fu_imm(fu_imm), .fu_pc(fu_pc),
    .fu_pc_jump(fu_pc_jump), .fu_pc_wb(fu_pc_wb), .fu_cmp_res(fu_cmp_res),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .exc_misalign(exc_misalign),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef JUMP_STATS_EN
    .stat_taken(stat_taken), .stat_not_taken(stat_not_taken),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        jalr;
    logic [2:0]  cmp;
    logic [31:0] rs1, rs2, imm, pc;
    int          cyc;
  } op_t;
  typedef struct { logic [31:0] pc; int cyc; } redir_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_t;

  op_t    op_q[$];
  redir_t redir_q[$];
  int     exc_q[$];
  wb_t    wb_q[$];

  int model_taken = 0;
  int model_not_taken = 0;

  int          kill_cyc = -100;
  int          fu_cyc = -100;
  int          wb_lo = 0;
  int          wb_cnt = 0;
  logic [31:0] good_jump, good_wb;
  logic        good_cmp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // FU results are only meaningful in the one cycle the controller must sample them
  task automatic step();
    @(posedge clk);
    #1;
    kill = (cyc == kill_cyc);
    if (cyc == fu_cyc) begin
      fu_pc_jump = good_jump;
      fu_pc_wb   = good_wb;
      fu_cmp_res = good_cmp;
    end else begin
      fu_pc_jump = $urandom;
      fu_pc_wb   = $urandom;
      fu_cmp_res = 1'($urandom);
    end
    if (wb_valid) begin
      wb_ready = (wb_cnt >= wb_lo);
      wb_cnt++;
    end else begin
      wb_ready = 1'($urandom);
    end
  endtask

  task automatic run_op(input logic [2:0] cls, input logic [2:0] cmp,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] fj, input logic [31:0] fw, input logic fc,
                        input int koff, input int wlo, input bit rst_wb);
    int budget, a, exp_idle;
    bit killed, tk, mis, has_wb;
    logic [31:0] tgt;
    op_t o;
    redir_t r;
    wb_t w;
    step();
    {issue_jal, issue_jalr, issue_branch} = cls;
    issue_cmp_ctrl = cmp; issue_rs1_data = rs1; issue_rs2_data = rs2;
    issue_imm = imm; issue_pc = pc; issue_rd = rd;
    issue_valid = 1'b1;
    budget = 50;
    while (!issue_ready && budget > 0) begin step(); budget--; end
    if (!issue_ready) begin
      fail("accept_timeout");
      issue_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    fu_cyc = a + FU_LAT - 1;
    kill_cyc = (koff >= 0) ? a + koff : -100;
    good_jump = fj; good_wb = fw; good_cmp = fc;
    wb_lo = wlo; wb_cnt = 0;
    o.jalr = cls[1]; o.cmp = cmp; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.pc = pc; o.cyc = a;
    op_q.push_back(o);

    killed = (koff >= 0) && (koff <= FU_LAT);
    tk     = cls[2] || cls[1] || (cls[0] && fc);
    tgt    = cls[1] ? (fj & 32'hFFFF_FFFE) : fj;
    mis    = tk && tgt[1];
    has_wb = !killed && (cls[2] || cls[1]) && (rd != 5'd0) && !mis;
    if (!killed) begin
      if (mis) exc_q.push_back(a + FU_LAT + 1);
      else if (tk) begin r.pc = tgt; r.cyc = a + FU_LAT + 1; redir_q.push_back(r); end
      if (!mis) begin
        if (tk) model_taken++;
        else    model_not_taken++;
      end
      if (has_wb) begin w.rd = rd; w.data = fw; w.cyc = a + FU_LAT + 1; wb_q.push_back(w); end
    end
    exp_idle = killed ? a + koff + 1 : a + FU_LAT + 1;

    step();
    issue_valid = 1'b0;
    issue_rs1_data = $urandom; issue_pc = $urandom; issue_rd = 5'($urandom);
    budget = 40 + wlo;
    while (busy && budget > 0) begin
      if (rst_wb && wb_valid) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wb_busy", busy, 0);
        check("rst_wb_wb_valid", wb_valid, 0);
        #1;
        check("rst_wb_issue_ready", issue_ready, 1);
        void'(wb_q.pop_front());
        model_taken = 0;
        model_not_taken = 0;
        break;
      end
      step();
      budget--;
    end
    if (busy) fail("idle_timeout");
    else if (!has_wb && !rst_wb) begin
      check("idle_cycle", cyc, exp_idle);
      check("issue_ready_back", issue_ready, 1);
    end
    kill_cyc = -100;
    fu_cyc = -100;
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  bit prev_fu_en = 0, prev_rst = 0, wb_active = 0, prev_wb_hs = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (fu_en) begin
        if (prev_fu_en) fail("fu_en_wide");
        if (op_q.size() == 0) fail("unexpected_fu_en");
        else begin
          op_t e;
          e = op_q.pop_front();
          check("fu_en_cycle", cyc, e.cyc);
          check("fu_operands", {fu_jalr, fu_cmp_ctrl, fu_pc}, {e.jalr, e.cmp, e.pc});
          check("fu_rs", {fu_rs1_data, fu_rs2_data}, {e.rs1, e.rs2});
          check("fu_imm", fu_imm, e.imm);
        end
      end
      if (redirect_valid || flush) begin
        check("flush_vs_redirect", flush, redirect_valid);
        if (redirect_valid) begin
          if (redir_q.size() == 0) fail("unexpected_redirect");
          else begin
            redir_t e;
            e = redir_q.pop_front();
            check("redirect_pc", redirect_pc, e.pc);
            check("redirect_cycle", cyc, e.cyc);
          end
        end
      end
      if (exc_misalign) begin
        if (exc_q.size() == 0) fail("unexpected_exc");
        else check("exc_cycle", cyc, exc_q.pop_front());
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) fail("unexpected_wb");
        else begin
          if (!wb_active) check("wb_start_cycle", cyc, wb_q[0].cyc);
          check("wb_rd_data", {wb_rd, wb_data}, {wb_q[0].rd, wb_q[0].data});
          wb_active = 1;
          if (wb_ready) begin
            void'(wb_q.pop_front());
            wb_active = 0;
          end
        end
      end else if (wb_active) begin
        if (!prev_rst) fail("wb_dropped");
        wb_active = 0;
      end
      prev_fu_en = fu_en;
      prev_rst   = rst;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] cls;
    int koff;
    rst = 1'b1; issue_valid = 1'b0; issue_jal = 0; issue_jalr = 0; issue_branch = 0;
    issue_cmp_ctrl = 0; issue_rs1_data = 0; issue_rs2_data = 0; issue_imm = 0;
    issue_pc = 0; issue_rd = 0; kill = 0; fu_pc_jump = 0; fu_pc_wb = 0; fu_cmp_res = 0;
    wb_ready = 0;
    repeat (3) step();
    check("rst_issue_ready", issue_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {fu_en, redirect_valid, flush, exc_misalign, wb_valid}, 0);
    check("rst_data", {redirect_pc, wb_data}, 0);
    check("rst_fu_data", {fu_pc, fu_imm}, 0);
    rst = 1'b0;
    #1;
    check("post_rst_issue_ready", issue_ready, 1);

    // JAL with stalled writeback, BEQ not taken, JALR aligned/misaligned, killed BNE, reset in WB
    run_op(3'b100, 3'd0, 32'h0, 32'h0, 32'h20, 32'h100, 5'd1, 32'h120, 32'h104, 1'b0, -1, 3, 0);
    run_op(3'b001, 3'd0, 32'h5, 32'h6, 32'h40, 32'h200, 5'd0, 32'h240, 32'h204, 1'b0, -1, 0, 0);
    run_op(3'b010, 3'd0, 32'h2000, 32'h0, 32'h1, 32'h300, 5'd0, 32'h2001, 32'h304, 1'b0, -1, 0, 0);
    run_op(3'b010, 3'd0, 32'h2000, 32'h0, 32'h2, 32'h400, 5'd3, 32'h2002, 32'h404, 1'b0, -1, 0, 0);
    run_op(3'b001, 3'd1, 32'h1, 32'h2, 32'h80, 32'h500, 5'd0, 32'h580, 32'h504, 1'b1, FU_LAT, 0, 0);
    run_op(3'b100, 3'd0, 32'h0, 32'h0, 32'h10, 32'h600, 5'd5, 32'h610, 32'h604, 1'b0, -1, 1000, 1);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: cls = 3'b100;
        1: cls = 3'b010;
        default: cls = 3'b001;
      endcase
      koff = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FU_LAT + 3)) : -1;
      run_op(cls, 3'($urandom), $urandom, $urandom, $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             $urandom, $urandom, 1'($urandom), koff, $urandom_range(0, 3), 0);
    end

    repeat (5) step();
    check("op_q_empty", op_q.size(), 0);
    check("redir_q_empty", redir_q.size(), 0);
    check("exc_q_empty", exc_q.size(), 0);
    check("wb_q_empty", wb_q.size(), 0);
`ifdef JUMP_STATS_EN
    check("stat_taken", stat_taken, model_taken);
    check("stat_not_taken", stat_not_taken, model_not_taken);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jump_issue_ctrl.md
Name: jump_issue_ctrl

Overview:
- Dispatch-and-resolve controller for the jump functional unit: accepts one JAL/JALR/branch from the issue stage and drives the FU operands with a single-cycle enable.
- Waits the FU latency, samples the jump target, link value and compare result, then decides taken/not-taken.
- Issues the fetch redirect and flush, and returns the link value (PC+4) to the register file through a valid/ready writeback port.
- Sits between the scoreboard issue logic and the jump FU; one instruction in flight.

Parameters:
- FU_LAT, 2, cycles from the fu_en cycle (index 0) to the cycle whose end samples the FU results (index FU_LAT-1); legal range 1..7.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  jump instruction offered
- issue_ready  out  1  controller idle, can accept
- issue_jal / issue_jalr / issue_branch  in  1 each  one-hot op class
- issue_cmp_ctrl  in  3  branch compare code
- issue_rs1_data, issue_rs2_data, issue_imm, issue_pc  in  32 each  operands
- issue_rd  in  5  link destination
- kill  in  1  abort in-flight op (older exception)
- fu_en  out  1  FU enable, one-cycle pulse
- fu_jalr  out  1  to FU
- fu_cmp_ctrl  out  3  to FU
- fu_rs1_data, fu_rs2_data, fu_imm, fu_pc  out  32 each  to FU
- fu_pc_jump, fu_pc_wb  in  32 each  from FU
- fu_cmp_res  in  1  from FU
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  32  new fetch PC
- flush  out  1  younger-instruction flush pulse
- exc_misalign  out  1  misaligned-target exception pulse
- wb_valid  out  1  link writeback request
- wb_ready  in  1  regfile accepts
- wb_rd  out  5  link destination
- wb_data  out  32  link value
- busy  out  1  state != IDLE

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; fu_en, redirect_valid, flush, exc_misalign, wb_valid=0; all data outputs=0; issue_ready=0 while rst is high.
- issue_ready = (state==IDLE) & ~rst, combinational. Handshake completes on the clock edge where issue_valid & issue_ready.
- IDLE:
  - On accept, latch all issue_* fields into fu_* / internal registers, clear cycle counter, go to EXEC.
- EXEC:
  - fu_en=1 only in cycle index 0; fu_* operands held stable for all of EXEC.
  - Counter increments each cycle.
  - At the end of cycle index FU_LAT-1, capture fu_pc_jump, fu_pc_wb, fu_cmp_res; go to RESOLVE.
- RESOLVE (1 cycle):
  - taken = jal | jalr | (branch & cmp_res).
  - Target = captured pc_jump with bit0 forced to 0 when jalr.
  - taken & target[1]: exc_misalign=1; no redirect, no flush, no writeback; go to IDLE.
  - taken & aligned: redirect_valid=1, flush=1, redirect_pc=target.
  - Not taken: no pulses.
  - Next state is WB if (jal|jalr) & rd!=0 & no exception; otherwise IDLE.
- WB:
  - wb_valid=1, wb_rd=latched rd, wb_data=captured pc_wb; held stable until wb_ready.
  - Leave to IDLE on the edge where wb_valid & wb_ready. No timeout.
- All pulses (fu_en, redirect_valid, flush, exc_misalign) are registered and exactly one cycle wide.
- kill:
  - In EXEC or RESOLVE: next state IDLE, and any RESOLVE pulses in that same cycle are suppressed (kill wins).
  - In WB: ignored; writeback completes.
  - In IDLE: ignored.
- No back-to-back issue: the earliest next accept is the cycle after returning to IDLE.
- rst asserted in any state: next state IDLE, pending writeback dropped, counter cleared.
- Arithmetic: counter width 3 bits; no addition is done locally (targets come from the FU); rd==0 suppresses writeback.

Optional Feature:
- Macro JUMP_STATS_EN.
- Defined: adds outputs stat_taken[31:0] and stat_not_taken[31:0], counting resolved jumps at RESOLVE.
  - Killed ops and misaligned ops are not counted.
  - Counters wrap at 2^32; cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- JAL pc=0x100 imm=0x20 rd=1, FU_LAT=2, FU returns jump=0x120 wb=0x104 -> fu_en for 1 cycle; RESOLVE 2 cycles later with redirect_pc=0x120 and flush pulse; then wb_valid with rd=1, data=0x104; wb_ready held low 3 cycles -> wb_valid and data stay stable; idle after handshake.
- BEQ not taken (cmp_res=0) -> no redirect, no flush, no wb_valid; issue_ready returns 4 cycles after accept.
- JALR rd=0, FU jump=0x2001 -> redirect_pc=0x2000, flush pulse; no writeback. FU jump=0x2002 -> exc_misalign pulse only.
- kill asserted in the cycle RESOLVE would pulse for a taken BNE -> redirect_valid, flush, exc_misalign all stay 0; state IDLE next cycle.
- rst asserted while in WB with wb_ready=0 -> next cycle wb_valid=0, busy=0; issue_ready=1 after rst deasserts.
- FU_LAT=1 and FU_LAT=5 with a JAL -> redirect 2 and 6 cycles after the fu_en cycle respectively. With JUMP_STATS_EN, 3 taken + 2 not-taken + 1 killed -> stat_taken=3, stat_not_taken=2.
